// File: rtl/cube_pkg.sv
// Constants shared between the cube unit and its downstream accumulator:
// cube result width and the two-state encoding of the accumulator FSM.
package cube_pkg;

    localparam int CUBE_W = 24;

    localparam logic ACCUM = 1'b0;
    localparam logic HOLD  = 1'b1;

endpackage

// File: rtl/cube_sum_adder.sv
// Combinational accumulator adder with carry-out; build option CUBE_SUM_SAT_EN
// selects clamping to all-ones on carry instead of modulo wrap.
module cube_sum_adder
    import cube_pkg::*;
#(
    parameter int IN_W  = CUBE_W,
    parameter int SUM_W = 32
) (
    input  logic [SUM_W-1:0] i_acc,
    input  logic [IN_W-1:0]  i_cube,
    output logic [SUM_W-1:0] o_sum,
    output logic             o_carry
);

    logic [SUM_W:0] w_full;

    assign w_full  = {1'b0, i_acc} + {{(SUM_W + 1 - IN_W){1'b0}}, i_cube};
    assign o_carry = w_full[SUM_W];

`ifdef CUBE_SUM_SAT_EN
    // Once clamped, any further non-zero term carries again and stays clamped.
    assign o_sum = o_carry ? {SUM_W{1'b1}} : w_full[SUM_W-1:0];
`else
    assign o_sum = w_full[SUM_W-1:0];
`endif

endmodule

// File: rtl/cube_sum_acc.sv
// Sums N_TERMS cube results per frame and offers the sum on a valid/ready
// output register. Overflow mode is set by the CUBE_SUM_SAT_EN build option.
//
// Handshakes: a term transfers on a rising edge where in_valid && in_ready;
// a sum transfers on a rising edge where sum_valid && sum_ready. in_ready is
// high only in ACCUM, so no term is accepted while a sum is waiting.
module cube_sum_acc
    import cube_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int IN_W    = CUBE_W,
    parameter int SUM_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_cube,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SUM_W-1:0] sum_out,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             sum_ovf,
    output logic [7:0]       term_count,
    output logic             dbg_state
);

    localparam logic [7:0] LAST_IDX = 8'(N_TERMS - 1);

    logic             r_state;
    logic             w_state_nxt;
    logic [SUM_W-1:0] r_acc;
    logic [7:0]       r_count;
    logic             r_ovf;
    logic [SUM_W-1:0] r_sum;
    logic             r_sum_ovf;
    logic             r_sum_valid;

    logic [SUM_W-1:0] w_sum;
    logic             w_carry;
    logic             w_accept;
    logic             w_last;

    cube_sum_adder #(
        .IN_W  (IN_W),
        .SUM_W (SUM_W)
    ) u_adder (
        .i_acc   (r_acc),
        .i_cube  (in_cube),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    assign w_accept = in_valid && (r_state == ACCUM);
    assign w_last   = w_accept && (r_count == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (w_last)    w_state_nxt = HOLD;
            HOLD:    if (sum_ready) w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        in_ready = (r_state == ACCUM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_sum       <= '0;
            r_sum_ovf   <= 1'b0;
            r_sum_valid <= 1'b0;
        end else if (w_last) begin
            // Closing term: publish the sum and start the next frame clean.
            r_sum       <= w_sum;
            r_sum_ovf   <= r_ovf | w_carry;
            r_sum_valid <= 1'b1;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= w_sum;
            r_count <= r_count + 8'd1;
            r_ovf   <= r_ovf | w_carry;
        end else if ((r_state == HOLD) && sum_ready) begin
            r_sum_valid <= 1'b0;
        end
    end

    assign sum_out    = r_sum;
    assign sum_valid  = r_sum_valid;
    assign sum_ovf    = r_sum_ovf;
    assign term_count = r_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_cube_sum_acc.sv
// Bench for cube_sum_acc: three instances (default, SUM_W=25, N_TERMS=1) checked
// every cycle against a frame-level arithmetic model, plus directed scenarios.
module tb_cube_sum_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] c_cube [3];
    logic        c_valid[3];
    logic        c_sready[3];

    logic        o_ready[3];
    logic        o_valid[3];
    logic        o_ovf[3];
    logic [7:0]  o_count[3];
    logic        o_state[3];
    logic [31:0] so0, so2;
    logic [24:0] so1;
    logic [31:0] o_sum[3];

    assign o_sum[0] = so0;
    assign o_sum[1] = {7'd0, so1};
    assign o_sum[2] = so2;

    always #5 clk = ~clk;

    cube_sum_acc u_d0 (
        .clk(clk), .rst(rst), .in_cube(c_cube[0]), .in_valid(c_valid[0]),
        .in_ready(o_ready[0]), .sum_out(so0), .sum_valid(o_valid[0]),
        .sum_ready(c_sready[0]), .sum_ovf(o_ovf[0]), .term_count(o_count[0]),
        .dbg_state(o_state[0])
    );

    cube_sum_acc #(.SUM_W(25)) u_d1 (
        .clk(clk), .rst(rst), .in_cube(c_cube[1]), .in_valid(c_valid[1]),
        .in_ready(o_ready[1]), .sum_out(so1), .sum_valid(o_valid[1]),
        .sum_ready(c_sready[1]), .sum_ovf(o_ovf[1]), .term_count(o_count[1]),
        .dbg_state(o_state[1])
    );

    cube_sum_acc #(.N_TERMS(1)) u_d2 (
        .clk(clk), .rst(rst), .in_cube(c_cube[2]), .in_valid(c_valid[2]),
        .in_ready(o_ready[2]), .sum_out(so2), .sum_valid(o_valid[2]),
        .sum_ready(c_sready[2]), .sum_ovf(o_ovf[2]), .term_count(o_count[2]),
        .dbg_state(o_state[2])
    );

    // Reference model: terms collected per frame, sum computed with plain arithmetic.
    int     n_terms[3] = '{4, 4, 1};
    int     sum_w[3]   = '{32, 25, 32};
    int     m_cnt[3];
    longint m_total[3];
    bit     m_pend[3];
    longint m_sum[3];
    bit     m_ovf[3];

    int errors = 0;
    int checks = 0;

`ifdef CUBE_SUM_SAT_EN
    localparam logic [31:0] T3_SUM = 32'h1FFFFFF;
`else
    localparam logic [31:0] T3_SUM = 32'h0FFFFFD;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_cnt[d] = 0; m_total[d] = 0; m_pend[d] = 1'b0;
            m_sum[d] = 0; m_ovf[d] = 1'b0;
        end
    endtask

    task automatic model_edge();
        longint maxv;
        if (rst) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 3; d++) begin
            maxv = (longint'(1) << sum_w[d]) - 1;
            if (m_pend[d]) begin
                if (c_sready[d]) m_pend[d] = 1'b0;
            end else if (c_valid[d]) begin
                m_total[d] += longint'(c_cube[d]);
                m_cnt[d]++;
                if (m_cnt[d] == n_terms[d]) begin
`ifdef CUBE_SUM_SAT_EN
                    m_sum[d] = (m_total[d] > maxv) ? maxv : m_total[d];
`else
                    m_sum[d] = m_total[d] & maxv;
`endif
                    m_ovf[d]   = (m_total[d] > maxv);
                    m_pend[d]  = 1'b1;
                    m_cnt[d]   = 0;
                    m_total[d] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d_in_ready", d), o_ready[d], !m_pend[d]);
            chk($sformatf("d%0d_sum_valid", d), o_valid[d], m_pend[d]);
            chk($sformatf("d%0d_term_count", d), o_count[d], m_cnt[d]);
            chk($sformatf("d%0d_sum_out", d), o_sum[d], m_sum[d]);
            chk($sformatf("d%0d_sum_ovf", d), o_ovf[d], m_ovf[d]);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [23:0] c, input logic r);
        c_valid[d]  = v;
        c_cube[d]   = c;
        c_sready[d] = r;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 24'd0, 1'b0);
        model_reset();

        // Reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_in_ready", o_ready[0], 1'b1);
        chk("reset_sum_out", o_sum[0], 0);

        // Frame 1,8,27,64 with sum_ready high and in_valid held high
        drive(0, 1'b1, 24'd1, 1'b1);  tick();
        drive(0, 1'b1, 24'd8, 1'b1);  tick();
        drive(0, 1'b1, 24'd27, 1'b1); tick();
        drive(0, 1'b1, 24'd64, 1'b1); tick();
        chk("t1_sum", o_sum[0], 100);
        chk("t1_valid", o_valid[0], 1'b1);
        chk("t1_ovf", o_ovf[0], 1'b0);
        chk("t1_in_ready_low", o_ready[0], 1'b0);
        drive(0, 1'b1, 24'd99, 1'b1); tick();
        chk("t1_valid_one_cycle", o_valid[0], 1'b0);
        chk("t1_in_ready_back", o_ready[0], 1'b1);
        chk("t1_hold_ignored", o_count[0], 0);

        // Frame 125,216,343,512 with consumer stalled
        drive(0, 1'b1, 24'd125, 1'b0); tick();
        drive(0, 1'b1, 24'd216, 1'b0); tick();
        drive(0, 1'b1, 24'd343, 1'b0); tick();
        drive(0, 1'b1, 24'd512, 1'b0); tick();
        chk("t2_sum", o_sum[0], 1196);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1'(k % 2), 24'd7, 1'b0); tick();
            chk("t2_stall_sum", o_sum[0], 1196);
            chk("t2_stall_valid", o_valid[0], 1'b1);
            chk("t2_stall_in_ready", o_ready[0], 1'b0);
            chk("t2_stall_count", o_count[0], 0);
        end
        drive(0, 1'b0, 24'd0, 1'b1); tick();
        chk("t2_released", o_valid[0], 1'b0);
        chk("t2_sum_held", o_sum[0], 1196);

        // Overflow on the SUM_W=25 instance
        for (int k = 0; k < 3; k++) begin
            drive(1, 1'b1, 24'hFFFFFF, 1'b1); tick();
        end
        drive(1, 1'b1, 24'd0, 1'b1); tick();
        chk("t3_sum", o_sum[1], T3_SUM);
        chk("t3_ovf", o_ovf[1], 1'b1);
        drive(1, 1'b0, 24'd0, 1'b1); tick();
        for (int k = 0; k < 4; k++) begin
            drive(1, 1'b1, 24'd1, 1'b1); tick();
        end
        chk("t3_next_sum", o_sum[1], 4);
        chk("t3_next_ovf", o_ovf[1], 1'b0);
        drive(1, 1'b0, 24'd0, 1'b1); tick();

        // Reset mid-frame
        drive(0, 1'b1, 24'd3, 1'b1); tick();
        drive(0, 1'b1, 24'd5, 1'b1); tick();
        chk("t4_partial_count", o_count[0], 2);
        drive(0, 1'b0, 24'd0, 1'b0);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("t4_rst_sum", o_sum[0], 0);
        chk("t4_rst_valid", o_valid[0], 1'b0);
        chk("t4_rst_ovf", o_ovf[0], 1'b0);
        chk("t4_rst_count", o_count[0], 0);
        chk("t4_rst_state", o_state[0], 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, 24'd1, 1'b1); tick();
        end
        chk("t4_sum", o_sum[0], 4);
        drive(0, 1'b0, 24'd0, 1'b1); tick();

        // N_TERMS=1 with gaps
        drive(2, 1'b1, 24'd8, 1'b1); tick();
        chk("t5_first", o_sum[2], 8);
        chk("t5_first_valid", o_valid[2], 1'b1);
        drive(2, 1'b0, 24'd0, 1'b1); tick();
        chk("t5_handshake", o_valid[2], 1'b0);
        drive(2, 1'b0, 24'd0, 1'b0); tick();
        drive(2, 1'b1, 24'd27, 1'b1); tick();
        chk("t5_second", o_sum[2], 27);
        drive(2, 1'b0, 24'd0, 1'b1); tick();

        // Random traffic on all instances
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 3; d++) begin
                drive(d, 1'($urandom_range(0, 9) < 7),
                      ($urandom_range(0, 1) == 1) ? 24'($urandom_range(24'hF00000, 24'hFFFFFF))
                                                  : 24'($urandom_range(0, 4095)),
                      1'($urandom_range(0, 1)));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
